// File: rtl/base_zynq_mpsoc_pkg.sv
// Shared constants, state encoding and byte-lane helper for the
// PS stand-in (OCM window + PL soft-reset register).
package base_zynq_mpsoc_pkg;

    localparam logic [31:0] OCM_BASE_ADDR  = 32'hFFFC0000;
    localparam logic [31:0] CSR_BASE_ADDR  = 32'hFF0A0000;
    localparam int unsigned OCM_WORDS_DEF  = 1024;
    localparam int unsigned NUM_PL_RST_DEF = 4;

    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_INIT = 2'd2
    } state_t;

    // Byte enables for a legal size starting at the given lane
    function automatic logic [3:0] lane_mask(
        input logic [2:0] size,
        input logic [1:0] lane
    );
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m << lane;
    endfunction

endpackage

// File: rtl/mpsoc_ocm_ram.sv
// OCM storage: single-port, byte-enable writes, synchronous read.
// The read register only updates on a read, so data holds during backpressure.
module mpsoc_ocm_ram #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];
    logic [31:0] r_q;

    // Byte-lane write or registered read of one word
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
            if (i_we == 4'b0000) begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/base_zynq_mpsoc_wrapper.sv
// PS stand-in top: host request/response port, OCM + soft-reset CSR, PL resets.
// Define OCM_INIT_EN to zero the OCM after every reset release.
module base_zynq_mpsoc_wrapper
    import base_zynq_mpsoc_pkg::*;
#(
    parameter logic [31:0] OCM_BASE   = OCM_BASE_ADDR,
    parameter int unsigned OCM_WORDS  = OCM_WORDS_DEF,
    parameter logic [31:0] CSR_BASE   = CSR_BASE_ADDR,
    parameter int unsigned NUM_PL_RST = NUM_PL_RST_DEF
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  por_srstb_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [2:0]            req_size,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [NUM_PL_RST-1:0] pl_resetn
);

    localparam int unsigned AW        = $clog2(OCM_WORDS);
    localparam logic [31:0] OCM_BYTES = 32'(4 * OCM_WORDS);

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [31:0]           r_rdata;
    logic                  r_ocm_rd;
    logic [1:0]            r_lane;
    logic [2:0]            r_size;
    logic [NUM_PL_RST-1:0] r_softrst;
    logic [NUM_PL_RST-1:0] r_pl_resetn;
    logic                  r_arst_q;
    logic                  r_por_q;

    logic          w_accept;
    logic [31:0]   w_off;
    logic          w_ocm_hit;
    logic          w_csr_hit;
    logic          w_size_ok;
    logic          w_align_ok;
    logic          w_ok;
    logic          w_ocm_acc;
    logic          w_csr_wr;
    logic          w_csr_rd;
    logic [31:0]   w_csr_data;
    logic          w_init_we;
    logic [AW-1:0] w_init_addr;
    logic          w_ram_en;
    logic [3:0]    w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_ram_q;
    logic [31:0]   w_rd_shift;
    logic [31:0]   w_rd_data;

`ifdef OCM_INIT_EN
    localparam state_t ST_BOOT = ST_INIT;

    logic [AW-1:0] r_init_cnt;

    assign w_init_we   = (r_state == ST_INIT) & por_srstb_n;
    assign w_init_addr = r_init_cnt;

    // Walk the OCM one word per cycle while in INIT
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_init_cnt <= '0;
        end else if (!por_srstb_n || r_state != ST_INIT) begin
            r_init_cnt <= '0;
        end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end
    end
`else
    localparam state_t ST_BOOT = ST_IDLE;

    assign w_init_we   = 1'b0;
    assign w_init_addr = '0;
`endif

    // Address decode and legality; unsigned offset handles below-base wrap
    assign w_accept   = req_valid & r_req_ready & por_srstb_n;
    assign w_off      = req_addr - OCM_BASE;
    assign w_ocm_hit  = w_off < OCM_BYTES;
    assign w_csr_hit  = req_addr == CSR_BASE;
    assign w_size_ok  = (req_size == SZ_BYTE) | (req_size == SZ_HALF) |
                        (req_size == SZ_WORD);
    assign w_align_ok = !((req_size == SZ_HALF && req_addr[0]) ||
                          (req_size == SZ_WORD && req_addr[1:0] != 2'b00));
    assign w_ok       = w_size_ok & w_align_ok &
                        (w_ocm_hit | (w_csr_hit & req_size == SZ_WORD));
    assign w_ocm_acc  = w_accept & w_ok & w_ocm_hit;
    assign w_csr_wr   = w_accept & w_ok & w_csr_hit & req_write;
    assign w_csr_rd   = w_accept & w_ok & w_csr_hit & ~req_write;
    assign w_csr_data = 32'(r_softrst);

    // RAM port is shared between the init walker and host accesses
    assign w_ram_en    = w_ocm_acc | w_init_we;
    assign w_ram_we    = w_init_we ? 4'b1111 :
                         (req_write ? lane_mask(req_size, req_addr[1:0]) : 4'b0000);
    assign w_ram_addr  = w_init_we ? w_init_addr : req_addr[AW+1:2];
    assign w_ram_wdata = w_init_we ? 32'h0 : (req_wdata << {req_addr[1:0], 3'b000});

    mpsoc_ocm_ram #(
        .WORDS (OCM_WORDS),
        .AW    (AW)
    ) u_ram (
        .i_clk   (aclk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    // Right-justify the selected bytes of the read word
    always_comb begin
        w_rd_shift = w_ram_q >> {r_lane, 3'b000};
        case (r_size)
            SZ_BYTE: w_rd_data = {24'h0, w_rd_shift[7:0]};
            SZ_HALF: w_rd_data = {16'h0, w_rd_shift[15:0]};
            default: w_rd_data = w_rd_shift;
        endcase
    end

    // Controller: accept, decode, CSR update and response hold
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_BOOT;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= '0;
            r_ocm_rd     <= 1'b0;
            r_lane       <= '0;
            r_size       <= '0;
            r_softrst    <= '0;
        end else if (!por_srstb_n) begin
            r_state      <= ST_BOOT;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= '0;
            r_ocm_rd     <= 1'b0;
            r_lane       <= '0;
            r_size       <= '0;
            r_softrst    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= ~w_accept;
                    if (w_accept) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= ~w_ok;
                        r_ocm_rd     <= w_ocm_acc & ~req_write;
                        r_lane       <= req_addr[1:0];
                        r_size       <= req_size;
                        r_rdata      <= w_csr_rd ? w_csr_data : 32'h0;
                        if (w_csr_wr) begin
                            r_softrst <= req_wdata[NUM_PL_RST-1:0];
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                    end
                end
`ifdef OCM_INIT_EN
                ST_INIT: begin
                    if (r_init_cnt == AW'(OCM_WORDS - 1)) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state     <= ST_BOOT;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    // PL resets: qualified by both reset sources and the soft-reset bits
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_arst_q    <= 1'b0;
            r_por_q     <= 1'b0;
            r_pl_resetn <= '0;
        end else begin
            r_arst_q    <= 1'b1;
            r_por_q     <= por_srstb_n;
            r_pl_resetn <= {NUM_PL_RST{por_srstb_n & r_arst_q & r_por_q}} &
                           ~r_softrst;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_ocm_rd ? w_rd_data : r_rdata;
    assign pl_resetn  = r_pl_resetn;

endmodule

// File: tb/tb_base_zynq_mpsoc_wrapper.sv
// Bench for base_zynq_mpsoc_wrapper: directed table, corner sequences and
// random traffic against a byte-array reference model.
module tb_base_zynq_mpsoc_wrapper;

    localparam int OCM_WORDS = 1024;
`ifdef OCM_INIT_EN
    localparam int READY_DLY = OCM_WORDS;
`else
    localparam int READY_DLY = 1;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        por_srstb_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_size = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  pl_resetn;

    base_zynq_mpsoc_wrapper dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .por_srstb_n (por_srstb_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .pl_resetn   (pl_resetn)
    );

    always #5 aclk = ~aclk;

    int vecs = 0;
    int errs = 0;

    logic [7:0] m_ocm [0:4*OCM_WORDS-1];
    logic [3:0] m_soft = 4'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed OCM, one CSR, legality from the address map
    function automatic void model(input bit wr, input logic [31:0] a,
                                  input logic [2:0] sz, input logic [31:0] wd,
                                  output logic [31:0] rd, output bit er);
        int n;
        logic [31:0] off;
        n = int'(sz);
        off = a - 32'hFFFC0000;
        rd = 32'h0;
        er = 1'b0;
        if (!(n == 1 || n == 2 || n == 4) || (a % 32'(n)) != 0) begin
            er = 1'b1;
        end else if (a >= 32'hFFFC0000 && a < 32'hFFFC0000 + 4 * OCM_WORDS) begin
            for (int i = 0; i < n; i++) begin
                if (wr) m_ocm[off + i] = wd[8*i +: 8];
                else    rd[8*i +: 8] = m_ocm[off + i];
            end
        end else if (a == 32'hFF0A0000 && n == 4) begin
            if (wr) m_soft = wd[3:0];
            else    rd = {28'h0, m_soft};
        end else begin
            er = 1'b1;
        end
    endfunction

    // One full transaction; checks the 1-cycle response latency
    task automatic xact(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n;
        @(negedge aclk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_size  = sz;
        req_wdata = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 2000) begin
            errs++;
            $display("FAIL accept_timeout: got ready=%b expected 1", req_ready);
        end
        @(posedge aclk);
        #1 req_valid = 1'b0;
        @(negedge aclk);
        chk("resp_latency", {31'h0, resp_valid}, 32'h1);
        rd = resp_rdata;
        er = resp_err;
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (req_ready !== 1'b1 && n < 5000);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          er;
        logic [3:0]  pl;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [31:0] rd, exp_rd, a, wd;
        logic        er;
        bit          exp_er, wr;
        logic [3:0]  exp_pl;
        logic [2:0]  sz;
        logic [31:0] bnd[3];
        logic [2:0]  szs[8];
        int          n, k;

        tbl[0]  = '{1'b1, 32'hFFFC0000, 3'd4, 32'hDEADBEEF, 32'h0,        1'b0, 4'hF};
        tbl[1]  = '{1'b0, 32'hFFFC0000, 3'd4, 32'h0,        32'hDEADBEEF, 1'b0, 4'hF};
        tbl[2]  = '{1'b1, 32'hFFFC0001, 3'd1, 32'h00000011, 32'h0,        1'b0, 4'hF};
        tbl[3]  = '{1'b0, 32'hFFFC0000, 3'd4, 32'h0,        32'hDEAD11EF, 1'b0, 4'hF};
        tbl[4]  = '{1'b0, 32'hFFFC0002, 3'd2, 32'h0,        32'h0000DEAD, 1'b0, 4'hF};
        tbl[5]  = '{1'b0, 32'hFFFC0001, 3'd1, 32'h0,        32'h00000011, 1'b0, 4'hF};
        tbl[6]  = '{1'b0, 32'h00000000, 3'd4, 32'h0,        32'h0,        1'b1, 4'hF};
        tbl[7]  = '{1'b0, 32'hFFFC0002, 3'd4, 32'h0,        32'h0,        1'b1, 4'hF};
        tbl[8]  = '{1'b1, 32'hFFFC0000, 3'd3, 32'h12345678, 32'h0,        1'b1, 4'hF};
        tbl[9]  = '{1'b1, 32'hFFFC0001, 3'd2, 32'h0000ABCD, 32'h0,        1'b1, 4'hF};
        tbl[10] = '{1'b0, 32'hFFFC0000, 3'd4, 32'h0,        32'hDEAD11EF, 1'b0, 4'hF};
        tbl[11] = '{1'b1, 32'hFF0A0000, 3'd4, 32'h00000001, 32'h0,        1'b0, 4'hE};
        tbl[12] = '{1'b0, 32'hFF0A0000, 3'd4, 32'h0,        32'h00000001, 1'b0, 4'hE};
        tbl[13] = '{1'b0, 32'hFF0A0000, 3'd2, 32'h0,        32'h0,        1'b1, 4'hE};
        tbl[14] = '{1'b1, 32'hFFFC0FFC, 3'd4, 32'hCAFEF00D, 32'h0,        1'b0, 4'hE};
        tbl[15] = '{1'b0, 32'hFFFC0FFC, 3'd4, 32'h0,        32'hCAFEF00D, 1'b0, 4'hE};
        tbl[16] = '{1'b0, 32'hFFFC1000, 3'd4, 32'h0,        32'h0,        1'b1, 4'hE};
        tbl[17] = '{1'b1, 32'hFF0A0000, 3'd4, 32'h00000000, 32'h0,        1'b0, 4'hF};
        tbl[18] = '{1'b0, 32'hFF0A0004, 3'd4, 32'h0,        32'h0,        1'b1, 4'hF};

        bnd[0] = 32'hFFFC0FFC;
        bnd[1] = 32'hFFFC1000;
        bnd[2] = 32'hFFFBFFFC;
        szs[0] = 3'd1; szs[1] = 3'd2; szs[2] = 3'd4; szs[3] = 3'd4;
        szs[4] = 3'd3; szs[5] = 3'd0; szs[6] = 3'd1; szs[7] = 3'd2;

        for (int i = 0; i < 4 * OCM_WORDS; i++) m_ocm[i] = 8'h00;

        // Reset state
        #1 aresetn = 1'b0;
        #2;
        chk("rst_req_ready",  {31'h0, req_ready},  32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata,          32'h0);
        chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
        chk("rst_pl_resetn",  {28'h0, pl_resetn},  32'h0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        n = 1;
        @(negedge aclk);
        chk("pl_first_cycle", {28'h0, pl_resetn}, 32'h0);
        while (req_ready !== 1'b1 && n < 5000) begin
            @(negedge aclk);
            n++;
        end
        chk("ready_delay", 32'(n), 32'(READY_DLY));
        @(negedge aclk);
        chk("pl_released", {28'h0, pl_resetn}, 32'hF);

        // Directed table
        for (int i = 0; i < 19; i++) begin
            xact(tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd, rd, er);
            model(tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd, exp_rd, exp_er);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("tbl%0d_err", i), {31'h0, er}, {31'h0, tbl[i].er});
            chk($sformatf("tbl%0d_pl", i), {28'h0, pl_resetn}, {28'h0, tbl[i].pl});
        end

        // Prefill the random-traffic window with known data
        for (int w = 0; w < 16; w++) begin
            a  = 32'hFFFC0000 + 32'(4 * w);
            wd = $urandom;
            model(1'b1, a, 3'd4, wd, exp_rd, exp_er);
            xact(1'b1, a, 3'd4, wd, rd, er);
            chk("prefill_err", {31'h0, er}, {31'h0, exp_er});
        end

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 9);
            if (k <= 5)      a = 32'hFFFC0000 + 32'($urandom_range(0, 63));
            else if (k == 6) a = 32'hFF0A0000;
            else if (k == 7) a = bnd[$urandom_range(0, 2)];
            else if (k == 8) a = {1'b0, 31'($urandom)};
            else             a = 32'hFF0A0002;
            sz = szs[$urandom_range(0, 7)];
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            model(wr, a, sz, wd, exp_rd, exp_er);
            xact(wr, a, sz, wd, rd, er);
            exp_pl = ~m_soft;
            chk($sformatf("rnd%0d_rdata a=%h sz=%0d wr=%0d", t, a, sz, wr), rd, exp_rd);
            chk($sformatf("rnd%0d_err", t), {31'h0, er}, {31'h0, exp_er});
            chk($sformatf("rnd%0d_pl", t), {28'h0, pl_resetn}, {28'h0, exp_pl});
        end

        // Backpressure: response held stable while resp_ready is low
        model(1'b0, 32'hFFFC0004, 3'd4, 32'h0, exp_rd, exp_er);
        @(negedge aclk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'hFFFC0004;
        req_size   = 3'd4;
        chk("bp_ready_before", {31'h0, req_ready}, 32'h1);
        @(posedge aclk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            chk("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
            chk("bp_rdata", resp_rdata, exp_rd);
            chk("bp_err", {31'h0, resp_err}, 32'h0);
            chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
        end
        resp_ready = 1'b1;
        @(negedge aclk);
        chk("bp_release_valid", {31'h0, resp_valid}, 32'h0);
        chk("bp_release_ready", {31'h0, req_ready}, 32'h1);

        // Set some soft resets, then power-on reset for 10 cycles
        xact(1'b1, 32'hFF0A0000, 3'd4, 32'h5, rd, er);
        model(1'b1, 32'hFF0A0000, 3'd4, 32'h5, exp_rd, exp_er);
        chk("csr5_pl", {28'h0, pl_resetn}, 32'hA);
        @(negedge aclk);
        por_srstb_n = 1'b0;
        repeat (10) begin
            @(negedge aclk);
            chk("por_pl_low", {28'h0, pl_resetn}, 32'h0);
            chk("por_req_ready", {31'h0, req_ready}, 32'h0);
        end
        por_srstb_n = 1'b1;
        m_soft = 4'h0;
`ifdef OCM_INIT_EN
        for (int i = 0; i < 4 * OCM_WORDS; i++) m_ocm[i] = 8'h00;
`endif
        wait_ready(n);
        chk("por_ready_delay", 32'(n), 32'(READY_DLY));
        xact(1'b0, 32'hFF0A0000, 3'd4, 32'h0, rd, er);
        chk("por_csr_rdata", rd, 32'h0);
        chk("por_csr_err", {31'h0, er}, 32'h0);
        chk("por_pl_released", {28'h0, pl_resetn}, 32'hF);
        model(1'b0, 32'hFFFC0000, 3'd4, 32'h0, exp_rd, exp_er);
        xact(1'b0, 32'hFFFC0000, 3'd4, 32'h0, rd, er);
        chk("por_ocm_kept", rd, exp_rd);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
